// File: rtl/uart_rx_word.sv
// Two-byte UART receiver: assembles consecutive 8N1 bytes into one 16-bit word.
// Optional macro UART_RX_MAJORITY_EN selects a 2-of-3 mid-bit vote instead of a single sample.
module uart_rx_word #(
   parameter int OVS      = 16,
   parameter int GAP_BITS = 20
) (
   input  logic        clk_153k6hz,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] data,
   output logic        valid,
   output logic        frame_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

   localparam int CW      = $clog2(OVS);
   localparam int GAP_LIM = GAP_BITS * OVS;
   localparam int GW      = $clog2(GAP_LIM);

   localparam logic [CW-1:0] BIT_PT   = CW'(OVS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIM - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] START_PT = CW'(OVS / 2);
`else
   localparam logic [CW-1:0] START_PT = CW'(OVS / 2 - 1);
`endif

   state_t          state_q, state_d;
   logic            rx_s1_q, rxs_q, rxs_prev_q;
   logic [1:0]      fill_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [2:0]      bidx_q, bidx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      shadow_q, shadow_d;
   logic            hi_q, hi_d;
   logic [15:0]     data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            samp;
   logic            fell;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0]      hist_q;

   always_ff @(posedge clk_153k6hz or negedge rst_n) begin
      if (!rst_n) hist_q <= '1;
      else        hist_q <= {hist_q[0], rxs_q};
   end

   assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
   assign samp = rxs_q;
`endif

   // Edge detector stays disarmed until the synchronizer holds real line samples,
   // so a line already low at reset release cannot fake a start edge.
   assign fell = rxs_prev_q & ~rxs_q;

   always_ff @(posedge clk_153k6hz or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b0;
         fill_q     <= '0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         bidx_q     <= '0;
         shreg_q    <= '0;
         shadow_q   <= '0;
         hi_q       <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rxs_q      <= rx_s1_q;
         rxs_prev_q <= rxs_q & fill_q[1];
         fill_q     <= {fill_q[0], 1'b1};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         bidx_q     <= bidx_d;
         shreg_q    <= shreg_d;
         shadow_q   <= shadow_d;
         hi_q       <= hi_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      bidx_d   = bidx_q;
      shreg_d  = shreg_q;
      shadow_d = shadow_q;
      hi_d     = hi_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (fell) begin
               state_d = START;
               cnt_d   = '0;
               hi_d    = 1'b0;
            end
         end
         START: begin
            if (cnt_q == START_PT) begin
               cnt_d  = '0;
               bidx_d = '0;
               state_d = samp ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // Data/stop bits are timed one full bit after the start-bit decision point.
         DATA: begin
            if (cnt_q == BIT_PT) begin
               shreg_d = {samp, shreg_q[7:1]};
               cnt_d   = '0;
               if (bidx_q == 3'd7) state_d = STOP;
               else                bidx_d  = bidx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_PT) begin
               cnt_d = '0;
               if (!samp) begin
                  ferr_d  = 1'b1;
                  hi_d    = 1'b0;
                  state_d = IDLE;
               end else if (!hi_q) begin
                  shadow_d = shreg_q;
                  hi_d     = 1'b1;
                  gap_d    = '0;
                  state_d  = GAP;
               end else begin
                  data_d  = {shreg_q, shadow_q};
                  valid_d = 1'b1;
                  hi_d    = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (fell) begin
               state_d = START;
               cnt_d   = '0;
            end else if (gap_q == GAP_LAST) begin
               ferr_d  = 1'b1;
               hi_d    = 1'b0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed self-checking bench for uart_rx_word; expectations adapt to UART_RX_MAJORITY_EN.
module tb_uart_rx_word;

   localparam int OVS      = 16;
   localparam int GAP_BITS = 20;
   localparam int GAP_LIM  = GAP_BITS * OVS;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT_ADJ = 1;
   localparam logic [15:0] SPIKE_WORD = 16'h3CA5;
`else
   localparam int LAT_ADJ = 0;
   localparam logic [15:0] SPIKE_WORD = 16'hC35A;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic [15:0] data;
   logic        valid;
   logic        frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int v_pulses = 0, v_hi = 0, f_pulses = 0, f_hi = 0, f_last_cyc = 0;
   logic both_seen = 1'b0;
   logic v_prev = 1'b0, f_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx_word #(.OVS(OVS), .GAP_BITS(GAP_BITS)) dut (
      .clk_153k6hz(clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) v_hi++;
      if (valid && !v_prev) v_pulses++;
      if (frame_err) f_hi++;
      if (frame_err && !f_prev) begin
         f_pulses++;
         f_last_cyc = cyc;
      end
      if (valid && frame_err) both_seen = 1'b1;
      v_prev = valid;
      f_prev = frame_err;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic drive_bit(input logic v, input logic spk);
      for (int i = 0; i < OVS; i++) begin
         @(negedge clk);
         rx = v ^ (spk && (i == OVS / 2));
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic spk);
      drive_bit(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(b[k], spk);
      drive_bit(stop_v, 1'b0);
   endtask

   task automatic test_reset;
      rx = 1'b0;
      rst_n = 1'b0;
      wait_cycles(4);
      total++; if (data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", data); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      rst_n = 1'b1;
      wait_cycles(12 * OVS);
      drive_idle(4 * OVS);
      total++; if (v_pulses !== 0) begin bad++; $display("FAIL low_line_valid: got %0d want 0", v_pulses); end
      total++; if (f_pulses !== 0) begin bad++; $display("FAIL low_line_ferr: got %0d want 0", f_pulses); end
   endtask

   task automatic test_back_to_back;
      int v0, h0, f0;
      v0 = v_pulses; h0 = v_hi; f0 = f_pulses;
      send_byte(8'hA5, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b0);
      drive_idle(2 * OVS);
      total++; if (data !== 16'h3CA5) begin bad++; $display("FAIL b2b_data: got %h want 3ca5", data); end
      total++; if (v_pulses - v0 !== 1) begin bad++; $display("FAIL b2b_valid_cnt: got %0d want 1", v_pulses - v0); end
      total++; if (v_hi - h0 !== 1) begin bad++; $display("FAIL b2b_valid_width: got %0d want 1", v_hi - h0); end
      total++; if (f_pulses - f0 !== 0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", f_pulses - f0); end
   endtask

   task automatic test_stop_err;
      int v0, f0, fh0;
      v0 = v_pulses; f0 = f_pulses; fh0 = f_hi;
      send_byte(8'h12, 1'b0, 1'b0);
      drive_idle(2 * OVS);
      total++; if (f_pulses - f0 !== 1) begin bad++; $display("FAIL stop_ferr_cnt: got %0d want 1", f_pulses - f0); end
      total++; if (f_hi - fh0 !== 1) begin bad++; $display("FAIL stop_ferr_width: got %0d want 1", f_hi - fh0); end
      total++; if (v_pulses - v0 !== 0) begin bad++; $display("FAIL stop_valid: got %0d want 0", v_pulses - v0); end
      total++; if (data !== 16'h3CA5) begin bad++; $display("FAIL stop_data_hold: got %h want 3ca5", data); end
   endtask

   task automatic test_gap_timeout;
      int v0, f0, fh0, t0, lat;
      v0 = v_pulses; f0 = f_pulses; fh0 = f_hi;
      send_byte(8'h55, 1'b1, 1'b0);
      t0 = cyc;
      drive_idle(25 * OVS);
      lat = f_last_cyc - t0;
      total++; if (f_pulses - f0 !== 1) begin bad++; $display("FAIL gap_ferr_cnt: got %0d want 1", f_pulses - f0); end
      total++; if (f_hi - fh0 !== 1) begin bad++; $display("FAIL gap_ferr_width: got %0d want 1", f_hi - fh0); end
      total++; if (lat !== GAP_LIM + 4 - OVS / 2 + LAT_ADJ) begin
         bad++; $display("FAIL gap_ferr_time: got %0d want %0d", lat, GAP_LIM + 4 - OVS / 2 + LAT_ADJ);
      end
      total++; if (v_pulses - v0 !== 0) begin bad++; $display("FAIL gap_valid: got %0d want 0", v_pulses - v0); end
      v0 = v_pulses;
      send_byte(8'h01, 1'b1, 1'b0);
      send_byte(8'h02, 1'b1, 1'b0);
      drive_idle(2 * OVS);
      total++; if (data !== 16'h0201) begin bad++; $display("FAIL gap_next_data: got %h want 0201", data); end
      total++; if (v_pulses - v0 !== 1) begin bad++; $display("FAIL gap_next_valid: got %0d want 1", v_pulses - v0); end
   endtask

   task automatic test_glitch;
      int v0, f0;
      v0 = v_pulses; f0 = f_pulses;
      for (int i = 0; i < OVS / 4; i++) begin
         @(negedge clk);
         rx = 1'b0;
      end
      drive_idle(3 * OVS);
      total++; if (v_pulses - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", v_pulses - v0); end
      total++; if (f_pulses - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", f_pulses - f0); end
      total++; if (data !== 16'h0201) begin bad++; $display("FAIL glitch_data: got %h want 0201", data); end
   endtask

   task automatic test_reset_midframe;
      int v0, f0;
      v0 = v_pulses; f0 = f_pulses;
      drive_bit(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive_bit(1'b1, 1'b0);
      drive_idle(OVS / 2);
      rst_n = 1'b0;
      wait_cycles(3);
      total++; if (data !== 16'h0000) begin bad++; $display("FAIL midrst_data: got %h want 0000", data); end
      rst_n = 1'b1;
      drive_idle(2 * OVS);
      send_byte(8'h34, 1'b1, 1'b0);
      send_byte(8'h12, 1'b1, 1'b0);
      drive_idle(2 * OVS);
      total++; if (v_pulses - v0 !== 1) begin bad++; $display("FAIL midrst_valid: got %0d want 1", v_pulses - v0); end
      total++; if (f_pulses - f0 !== 0) begin bad++; $display("FAIL midrst_ferr: got %0d want 0", f_pulses - f0); end
      total++; if (data !== 16'h1234) begin bad++; $display("FAIL midrst_word: got %h want 1234", data); end
   endtask

   task automatic test_spike;
      int v0, f0;
      v0 = v_pulses; f0 = f_pulses;
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h3C, 1'b1, 1'b1);
      drive_idle(2 * OVS);
      total++; if (data !== SPIKE_WORD) begin bad++; $display("FAIL spike_data: got %h want %h", data, SPIKE_WORD); end
      total++; if (v_pulses - v0 !== 1) begin bad++; $display("FAIL spike_valid: got %0d want 1", v_pulses - v0); end
      total++; if (f_pulses - f0 !== 0) begin bad++; $display("FAIL spike_ferr: got %0d want 0", f_pulses - f0); end
   endtask

   task automatic test_exclusive;
      total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL valid_ferr_overlap: got %b want 0", both_seen); end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_stop_err;
      test_gap_timeout;
      test_glitch;
      test_reset_midframe;
      test_spike;
      test_exclusive;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
